mem_wait_ctrl: RTL and testbench
================================

MEM_WAIT_CTRL -- requirements
Module: mem_wait_ctrl

Interface
REQ-001 Parameter: WAIT_CYCLES, default 3, stall cycles inserted per data-memory access; legal range 0..15.
REQ-002 Parameter: CNT_W, default 16, width of the statistics counters.
REQ-003 clk  input  1  single clock; every flop is rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mem_req  input  1  MEM-stage instruction is a load or store (dmem read or write).
REQ-006 ext_stall  input  1  external or bench stall request.
REQ-007 trap_mem  input  1  trap instruction has reached the MEM stage.
REQ-008 stall  output  1  freezes every pipeline register and the PC.
REQ-009 mem_ready  output  1  data-memory result is valid this cycle.
REQ-010 halted  output  1  a trap has been taken; the pipeline is frozen.
REQ-011 stall_cnt  output  CNT_W  count of cycles in which stall was 1.
REQ-012 access_cnt  output  CNT_W  count of completed memory accesses.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT and HALT; a down-counter cnt, 4 bits wide, SHALL sit beside it.
REQ-014 IDLE behaviour:
- mem_req=1 with WAIT_CYCLES>0: fsm_stall=1 in that same cycle (combinational); next state WAIT, cnt loaded with WAIT_CYCLES-1.
- mem_req=1 with WAIT_CYCLES=0: fsm_stall=0 and mem_ready=1 combinationally; state stays IDLE.
REQ-015 WAIT behaviour:
- cnt!=0: fsm_stall=1 and cnt decrements.
- cnt==0: fsm_stall=0 and mem_ready=1.
REQ-016 WAIT with cnt==0 SHALL go to IDLE when ext_stall=0, and SHALL stay in WAIT with cnt==0 when ext_stall=1, so that one access never triggers two stall sequences.
REQ-017 stall SHALL equal fsm_stall OR ext_stall OR (state==HALT).
REQ-018 Each access SHALL stall for exactly WAIT_CYCLES consecutive cycles when ext_stall=0.
- The access completes on the clock edge that ends the mem_ready cycle.
- A mem_req that is still high in IDLE on the next cycle SHALL start a new access (back-to-back loads and stores).
REQ-019 ext_stall SHALL NOT pause cnt; the wait countdown continues underneath an external stall.
REQ-020 trap_mem=1 SHALL move the FSM to HALT on the next edge from any state.
- trap_mem takes priority over mem_req.
- HALT is sticky until reset: halted=1, stall=1, mem_ready=0.
- An access in progress is abandoned and is not counted.
REQ-021 A change of mem_req during WAIT SHALL be ignored.

Reset
REQ-022 While reset is high, asynchronously: state=IDLE, cnt=0, stall_cnt=0 and access_cnt=0.
- Output values during reset: halted=0, mem_ready=0, and stall=ext_stall.
REQ-023 A reset asserted mid-access or in HALT SHALL abort that access; the first edge after reset falls SHALL evaluate mem_req from IDLE.

Configuration
REQ-024 Macro STALL_STATS_EN:
- Defined: stall_cnt and access_cnt are implemented as saturating counters.
  - stall_cnt increments each cycle stall=1.
  - access_cnt increments each cycle mem_ready=1 that ends with the FSM leaving WAIT, or ending an IDLE zero-wait access.
- Not defined: no counter flops are built, and both outputs are tied to 0.

Verification
REQ-025 WAIT_CYCLES=3, a single load (mem_req held until release) -> stall=1 for exactly 3 cycles, mem_ready=1 in the 4th cycle, access_cnt=1, stall_cnt=3.
REQ-026 WAIT_CYCLES=3, two back-to-back loads -> stall pattern 1,1,1,0,1,1,1,0; access_cnt=2.
REQ-027 WAIT_CYCLES=2, ext_stall=1 for 5 cycles starting with the access cycle -> stall=1 for 5 cycles; FSM held in WAIT with mem_ready=1 until ext_stall falls; one access only; stall_cnt=5.
REQ-028 trap_mem=1 during WAIT (cnt=1) -> halted=1 and stall=1 from the next edge for 20+ cycles; access_cnt unchanged; reset returns halted=0 and stall=0.
REQ-029 WAIT_CYCLES=0, three consecutive loads -> stall never 1, mem_ready=1 for 3 cycles, access_cnt=3.
REQ-030 Build without STALL_STATS_EN, rerun REQ-025 -> identical stall and mem_ready waveform; stall_cnt=0 and access_cnt=0.

Source files
------------

// File: rtl/mem_wait_ctrl_if.sv
// Handshake bundle between the MEM stage and the data-memory wait-state controller.
// Carries the request/trap inputs, the stall/ready/halt outputs and the statistics counters.
interface mem_wait_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             mem_req;
  logic             ext_stall;
  logic             trap_mem;
  logic             stall;
  logic             mem_ready;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] access_cnt;

  modport master (
    output mem_req, ext_stall, trap_mem,
    input  stall, mem_ready, halted, stall_cnt, access_cnt
  );

  modport slave (
    input  mem_req, ext_stall, trap_mem,
    output stall, mem_ready, halted, stall_cnt, access_cnt
  );
endinterface

// File: rtl/mem_wait_ctrl.sv
// Data-memory wait-state controller: inserts WAIT_CYCLES stall cycles per access, halts on trap.
// Optional saturating stall/access statistics are built when STALL_STATS_EN is defined.
module mem_wait_ctrl #(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic            clk,
  input  logic            reset,
  mem_wait_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, HALT} state_t;

  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LD   = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       fsm_stall;
  logic       ready;
  logic       done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs are masked while reset is held so stall reduces to ext_stall.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fsm_stall = 1'b0;
    ready     = 1'b0;
    done      = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (bus.mem_req && !bus.trap_mem) begin
            if (ZERO_WAIT) begin
              ready = 1'b1;
              done  = 1'b1;
            end else begin
              fsm_stall = 1'b1;
              state_nxt = WAIT;
              cnt_nxt   = WAIT_LD;
            end
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            fsm_stall = 1'b1;
            cnt_nxt   = cnt - 4'd1;
          end else begin
            // Park at cnt==0 under ext_stall so the same access is not restarted.
            ready = 1'b1;
            if (!bus.ext_stall) begin
              state_nxt = IDLE;
              done      = 1'b1;
            end
          end
        end
        HALT: ;
        default: state_nxt = IDLE;
      endcase
      if (bus.trap_mem) begin
        state_nxt = HALT;
        done      = 1'b0;
      end
    end
  end

  assign bus.stall     = fsm_stall | bus.ext_stall | (state == HALT);
  assign bus.mem_ready = ready;
  assign bus.halted    = (state == HALT);

`ifdef STALL_STATS_EN
  logic [CNT_W-1:0] stall_q, acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      acc_q   <= '0;
    end else begin
      if (bus.stall && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      if (done && acc_q != '1)        acc_q   <= acc_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt  = stall_q;
  assign bus.access_cnt = acc_q;
`else
  logic unused_stats;
  assign unused_stats   = done;
  assign bus.stall_cnt  = '0;
  assign bus.access_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Self-checking bench for mem_wait_ctrl: three instances (3, 2 and 0 wait cycles) driven per scenario,
// cycle expectations queued at drive time and popped at the mid-cycle sample point.
module tb_mem_wait_ctrl;

`ifdef STALL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_wait_ctrl_if #(.CNT_W(16)) b3();
  mem_wait_ctrl_if #(.CNT_W(16)) b2();
  mem_wait_ctrl_if #(.CNT_W(2))  b0();

  mem_wait_ctrl #(.WAIT_CYCLES(3), .CNT_W(16)) u3 (.clk(clk), .reset(reset), .bus(b3));
  mem_wait_ctrl #(.WAIT_CYCLES(2), .CNT_W(16)) u2 (.clk(clk), .reset(reset), .bus(b2));
  mem_wait_ctrl #(.WAIT_CYCLES(0), .CNT_W(2))  u0 (.clk(clk), .reset(reset), .bus(b0));

  int checks   = 0;
  int failures = 0;
  logic [2:0] sbq[$];

  task automatic setin(int d, logic req, logic ext, logic trap);
    case (d)
      3:       begin b3.mem_req = req; b3.ext_stall = ext; b3.trap_mem = trap; end
      2:       begin b2.mem_req = req; b2.ext_stall = ext; b2.trap_mem = trap; end
      default: begin b0.mem_req = req; b0.ext_stall = ext; b0.trap_mem = trap; end
    endcase
  endtask

  // {stall, mem_ready, halted}
  function automatic logic [2:0] obs(int d);
    case (d)
      3:       return {b3.stall, b3.mem_ready, b3.halted};
      2:       return {b2.stall, b2.mem_ready, b2.halted};
      default: return {b0.stall, b0.mem_ready, b0.halted};
    endcase
  endfunction

  // {stall_cnt, access_cnt}, zero-extended
  function automatic logic [63:0] cnts(int d);
    case (d)
      3:       return {32'(b3.stall_cnt), 32'(b3.access_cnt)};
      2:       return {32'(b2.stall_cnt), 32'(b2.access_cnt)};
      default: return {32'(b0.stall_cnt), 32'(b0.access_cnt)};
    endcase
  endfunction

  task automatic drive(int d, logic req, logic ext, logic trap, logic [2:0] e);
    @(posedge clk); #2;
    setin(d, req, ext, trap);
    sbq.push_back(e);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    setin(3, 0, 0, 0); setin(2, 0, 0, 0); setin(0, 0, 0, 0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    setin(3, 0, 1, 0); setin(2, 0, 0, 0); setin(0, 1, 0, 0);
    #1 reset = 1'b1;
    #2;
    checks++;
    if (obs(3) !== 3'b100) begin
      failures++; $display("FAIL reset_w3 outs got %b want %b", obs(3), 3'b100);
    end
    checks++;
    if (obs(0) !== 3'b000) begin
      failures++; $display("FAIL reset_w0 outs got %b want %b", obs(0), 3'b000);
    end
    checks++;
    if (cnts(3) !== 64'd0 || cnts(0) !== 64'd0) begin
      failures++; $display("FAIL reset_cnts got %h/%h want 0", cnts(3), cnts(0));
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_single_load();
    logic [2:0]  e;
    logic [63:0] ce;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(3, (i < 4), 0, 0, (i < 3) ? 3'b100 : (i == 3) ? 3'b010 : 3'b000);
      e = sbq.pop_front();
      checks++;
      if (obs(3) !== e) begin
        failures++; $display("FAIL single_load cyc%0d outs got %b want %b", i, obs(3), e);
      end
    end
    ce = {32'(STATS ? 3 : 0), 32'(STATS ? 1 : 0)};
    checks++;
    if (cnts(3) !== ce) begin
      failures++; $display("FAIL single_load_cnts got %h want %h", cnts(3), ce);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  e;
    logic [63:0] ce;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(3, (i < 8), 0, 0, (i == 8) ? 3'b000 : (i % 4 == 3) ? 3'b010 : 3'b100);
      e = sbq.pop_front();
      checks++;
      if (obs(3) !== e) begin
        failures++; $display("FAIL back_to_back cyc%0d outs got %b want %b", i, obs(3), e);
      end
    end
    ce = {32'(STATS ? 6 : 0), 32'(STATS ? 2 : 0)};
    checks++;
    if (cnts(3) !== ce) begin
      failures++; $display("FAIL back_to_back_cnts got %h want %h", cnts(3), ce);
    end
  endtask

  task automatic test_ext_stall();
    logic [6:0]  reqv = 7'b0010101;
    logic [6:0]  extv = 7'b0011111;
    logic [2:0]  ex [7] = '{3'b100, 3'b100, 3'b110, 3'b110, 3'b110, 3'b010, 3'b000};
    logic [2:0]  e;
    logic [63:0] ce;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(2, reqv[i], extv[i], 0, ex[i]);
      e = sbq.pop_front();
      checks++;
      if (obs(2) !== e) begin
        failures++; $display("FAIL ext_stall cyc%0d outs got %b want %b", i, obs(2), e);
      end
    end
    ce = {32'(STATS ? 5 : 0), 32'(STATS ? 1 : 0)};
    checks++;
    if (cnts(2) !== ce) begin
      failures++; $display("FAIL ext_stall_cnts got %h want %h", cnts(2), ce);
    end
  endtask

  task automatic test_trap();
    logic [2:0]  e;
    logic [63:0] ce;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      if (i < 3) drive(3, (i == 0), 0, (i == 2), 3'b100);
      else       drive(3, 1'($urandom_range(0, 1)), 0, 0, 3'b101);
      e = sbq.pop_front();
      checks++;
      if (obs(3) !== e) begin
        failures++; $display("FAIL trap cyc%0d outs got %b want %b", i, obs(3), e);
      end
    end
    ce = {32'(STATS ? 24 : 0), 32'd0};
    checks++;
    if (cnts(3) !== ce) begin
      failures++; $display("FAIL trap_cnts got %h want %h", cnts(3), ce);
    end
    // Reset out of HALT with a request pending; first edge after release starts it from IDLE.
    @(posedge clk); #2;
    setin(3, 1, 0, 0);
    reset = 1'b1;
    #1;
    checks++;
    if (obs(3) !== 3'b000 || cnts(3) !== 64'd0) begin
      failures++; $display("FAIL trap_reset outs got %b cnts %h want 000 0", obs(3), cnts(3));
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (obs(3) !== 3'b100) begin
      failures++; $display("FAIL trap_restart outs got %b want %b", obs(3), 3'b100);
    end
    for (int i = 0; i < 4; i++) begin
      drive(3, (i < 3), 0, 0, (i < 2) ? 3'b100 : (i == 2) ? 3'b010 : 3'b000);
      e = sbq.pop_front();
      checks++;
      if (obs(3) !== e) begin
        failures++; $display("FAIL trap_restart cyc%0d outs got %b want %b", i, obs(3), e);
      end
    end
    ce = {32'(STATS ? 3 : 0), 32'(STATS ? 1 : 0)};
    checks++;
    if (cnts(3) !== ce) begin
      failures++; $display("FAIL trap_restart_cnts got %h want %h", cnts(3), ce);
    end
  endtask

  task automatic test_zero_wait();
    logic [2:0]  e;
    logic [63:0] ce;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, (i < 3), 0, 0, (i < 3) ? 3'b010 : 3'b000);
      e = sbq.pop_front();
      checks++;
      if (obs(0) !== e) begin
        failures++; $display("FAIL zero_wait cyc%0d outs got %b want %b", i, obs(0), e);
      end
    end
    ce = {32'd0, 32'(STATS ? 3 : 0)};
    checks++;
    if (cnts(0) !== ce) begin
      failures++; $display("FAIL zero_wait_cnts got %h want %h", cnts(0), ce);
    end
    // Two more accesses on the 2-bit counter must saturate at 3, not wrap.
    for (int i = 0; i < 3; i++) begin
      drive(0, (i < 2), 0, 0, (i < 2) ? 3'b010 : 3'b000);
      e = sbq.pop_front();
      checks++;
      if (obs(0) !== e) begin
        failures++; $display("FAIL zero_wait_sat cyc%0d outs got %b want %b", i, obs(0), e);
      end
    end
    checks++;
    if (cnts(0) !== ce) begin
      failures++; $display("FAIL zero_wait_sat_cnts got %h want %h", cnts(0), ce);
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_back_to_back();
    test_ext_stall();
    test_trap();
    test_zero_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
